fifo_wptr_full: RTL and testbench

Write-side pointer and flag logic for the async FIFO. Keeps the binary write pointer and its Gray-coded twin, and synchronises the read-side Gray pointer into this clock domain. From these it produces full, almost-full, fill level and overflow. It is the binary-to-Gray (encode) end of the pointer crossing whose decode end is the existing `gray2bin` block. It sits between the write client and the FIFO RAM write port.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/gray2bin.sv | 17 +
 rtl/ptr_sync.sv | 38 +++
 rtl/fifo_wptr_full.sv | 90 +++++++++
 tb/tb_fifo_wptr_full.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer helpers and default sizing.
package fifo_pkg;

  localparam int DEFAULT_AW          = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef logic [DEFAULT_AW:0] ptr_t;

  // Callers size-cast the result down to their own pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder for pointer crossings.
module gray2bin #(
  parameter int DW = 5
) (
  input  logic [DW-1:0] gray,
  output logic [DW-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < DW; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/ptr_sync.sv
// Multi-bit flop chain that brings a Gray pointer into the local clock domain.
module ptr_sync #(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];

  // Stage 0 takes the raw asynchronous input; each later stage takes its predecessor.
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag logic of the async FIFO: pointer, full,
// almost-full, fill level and overflow, all from the synchronised read pointer.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int AW          = DEFAULT_AW,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int AF_LEVEL    = (1 << AW) - 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          winc,
  input  logic [AW:0]   rptr_gray,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   wptr_gray,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);

  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wgray_q, wgray_d;
  logic [AW:0] level_q, level_d;
  logic [AW:0] rs_s, rbin_s;
  logic        full_q, full_d;
  logic        almost_full_q, almost_full_d;
  logic        overflow_q, overflow_d;
  logic        acc_s;

  ptr_sync #(
    .W      (AW + 1),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rptr_gray),
    .q   (rs_s)
  );

  gray2bin #(
    .DW (AW + 1)
  ) u_rptr_g2b (
    .gray (rs_s),
    .bin  (rbin_s)
  );

  // Flags are computed from the post-write pointer, so a write that fills
  // the FIFO raises full on the same edge it lands.
  always_comb begin
    acc_s         = winc & ~full_q & ~rst;
    wbin_d        = wbin_q + {{AW{1'b0}}, acc_s};
    wgray_d       = (AW+1)'(bin2gray(32'(wbin_d)));
    full_d        = (wgray_d == {~rs_s[AW:AW-1], rs_s[AW-2:0]});
    level_d       = wbin_d - rbin_s;
    almost_full_d = (level_d >= AF_THR);
    overflow_d    = winc & full_q;
  end

  // Write-side state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q        <= '0;
      wgray_q       <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wgray_q       <= wgray_d;
      level_q       <= level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wen         = acc_s;
  assign waddr       = wbin_q[AW-1:0];
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign level       = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: occupancy model plus directed pins and random traffic.
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       winc = 1'b1;
  logic [4:0] rptr_gray = 5'd0;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: write count, occupancy, read pointer as seen after the sync delay
  int m_wbin  = 0;
  int m_level = 0;
  int dl0     = 0;
  int dl1     = 0;
  bit m_full  = 1'b0;
  bit m_af    = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_acc   = 1'b0;

  always #5 clk = ~clk;

  fifo_wptr_full #(
    .AW          (4),
    .SYNC_STAGES (2),
    .AF_LEVEL    (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .winc        (winc),
    .rptr_gray   (rptr_gray),
    .wen         (wen),
    .waddr       (waddr),
    .wptr_gray   (wptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow)
  );

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  function automatic int g2b(input int g);
    int b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    return b & 31;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model updated on each edge, then compared against the DUT.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_wbin = 0; m_level = 0; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
        dl0 = 0; dl1 = 0;
      end else begin
        m_acc   = winc && !m_full;
        m_ovf   = winc && m_full;
        m_wbin  = (m_wbin + int'(m_acc)) & 31;
        m_level = (m_wbin - dl0) & 31;
        m_full  = (m_level == 16);
        m_af    = (m_level >= 12);
        dl0     = dl1;
        dl1     = g2b(int'(rptr_gray));
      end
      #1;
      chk("m_waddr", waddr, m_wbin & 15);
      chk("m_wptr_gray", wptr_gray, b2g(m_wbin));
      chk("m_full", full, m_full);
      chk("m_almost_full", almost_full, m_af);
      chk("m_level", level, m_level);
      chk("m_overflow", overflow, m_ovf);
      #3;
      chk("m_wen", wen, winc && !m_full && !rst);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] gtab [4];
    logic [4:0] prev;
    bit saw_wrap;
    int rbin_t;
    gtab[0] = 5'b00001; gtab[1] = 5'b00011; gtab[2] = 5'b00010; gtab[3] = 5'b00110;

    for (int i = 0; i < 3; i++) begin
      #1 chk("rst_wen", wen, 1'b0);
      step();
      chk("rst_wptr", wptr_gray, 5'd0);
      chk("rst_waddr", waddr, 4'd0);
      chk("rst_full", full, 1'b0);
      chk("rst_af", almost_full, 1'b0);
      chk("rst_level", level, 5'd0);
      chk("rst_ovf", overflow, 1'b0);
    end
    rst = 1'b0;

    // fill 16 entries with the read side idle
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("fill_waddr", waddr, i);
      chk("fill_wen", wen, 1'b1);
      step();
      if (i < 4) chk("fill_wptr", wptr_gray, gtab[i]);
      chk("fill_af", almost_full, (i >= 11));
      chk("fill_full", full, (i == 15));
    end
    chk("fill_level16", level, 5'd16);
    chk("fill_wptr16", wptr_gray, 5'b11000);

    for (int i = 0; i < 2; i++) begin
      #1 chk("ovf_wen", wen, 1'b0);
      step();
      chk("ovf_pulse", overflow, 1'b1);
      chk("ovf_wptr", wptr_gray, 5'b11000);
    end
    winc = 1'b0;
    step();
    chk("ovf_clear", overflow, 1'b0);

    // a single read becomes visible three edges later
    rptr_gray = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain_full", full, (i < 2));
    end
    chk("drain_level", level, 5'd15);

    rptr_gray = 5'(b2g(16));
    step(); step(); step();
    chk("empty_level", level, 5'd0);

    // steady stream with the reader tracking the writer, across the pointer wrap
    prev = wptr_gray;
    saw_wrap = 1'b0;
    winc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rptr_gray = 5'(b2g(m_wbin));
      step();
      chk("wrap_onebit", $countones(prev ^ wptr_gray), 1);
      if (prev == 5'b10000 && wptr_gray == 5'b00000) saw_wrap = 1'b1;
      prev = wptr_gray;
      if (i >= 2) chk("wrap_level", level, 5'd3);
    end
    chk("wrap_seen", saw_wrap, 1'b1);
    winc = 1'b0;

    rst = 1'b1;
    rptr_gray = 5'd0;
    step();
    rst = 1'b0;
    winc = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("mid_level7", level, 5'd7);
    rst = 1'b1;
    #1 chk("mid_rst_wen", wen, 1'b0);
    step();
    chk("mid_waddr", waddr, 4'd0);
    chk("mid_level", level, 5'd0);
    chk("mid_full", full, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_next_wen", wen, 1'b1);
    chk("mid_next_waddr", waddr, 4'd0);
    step();
    chk("mid_after_waddr", waddr, 4'd1);
    chk("mid_after_level", level, 5'd1);

    // random traffic: slow reader first, then fast reader
    rbin_t = 0;
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      winc = ($urandom_range(0, 3) != 0);
      if (rst) begin
        rbin_t = 0;
      end else if (((m_wbin - rbin_t) & 31) != 0 &&
                   $urandom_range(0, 3) < ((i < 200) ? 1 : 3)) begin
        rbin_t = (rbin_t + 1) & 31;
      end
      rptr_gray = 5'(b2g(rbin_t));
      step();
    end

    rst  = 1'b0;
    winc = 1'b0;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
